execute_muldiv_stage: RTL and testbench

- Parametrised next-generation execute stage for the MIPS pipeline: single-cycle ALU, registered EX/MEM outputs, pipelined multiplier, iterative divider and HI/LO accumulator.
- Multi-cycle ops raise Busy to stall decode.
- Conditional moves (MOVZ/MOVN) gate the register write strictly: no write when the condition fails.
- Sits between the ID/EX register and the memory stage.

---
 rtl/execute_muldiv_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_execute_muldiv_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_muldiv_stage.sv
// MIPS execute stage: single-cycle ALU, registered EX/MEM outputs,
// multi-cycle multiplier, restoring divider and HI/LO accumulator.
module execute_muldiv_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  InValid,
  input  logic [3:0]            Op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [DATA_WIDTH-1:0] Imm,
  input  logic                  ALUSrc,
  input  logic [4:0]            RtField,
  input  logic [4:0]            RdField,
  input  logic                  RegDst,
  input  logic                  RegWriteIn,
  input  logic [1:0]            MovCond,
  output logic                  Busy,
  output logic                  OutValid,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [4:0]            DestReg,
  output logic                  RegWriteOut,
  output logic                  ZeroOut,
  output logic [DATA_WIDTH-1:0] HiOut,
  output logic [DATA_WIDTH-1:0] LoOut
);

  localparam int W    = DATA_WIDTH;
  localparam int SW   = $clog2(W);
  localparam int CMAX = (W > MUL_LATENCY) ? W : MUL_LATENCY;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DIV    = 2'd2,
    DIVFIX = 2'd3
  } state_t;

  state_t state, stateNext;

  logic [CW-1:0]  cnt;
  logic [W-1:0]   hiReg, loReg;
  logic [W-1:0]   opB, aluRes, resNext;
  logic           wrNext, accept;
  logic           isMul, isDiv, isSingle;
  logic           movZ, movN;
  logic           mulSigned, divSigned;
  logic [2*W-1:0] aExt, bExt, product;
  logic [2*W-1:0] prodReg, acc, accNext;
  logic [1:0]     mulOp;
  logic [W-1:0]   magA, magB;
  logic [W-1:0]   divisor, quo, rem, dividend;
  logic [W-1:0]   qFix, rFix;
  logic [W:0]     remShift;
  logic           geq;
  logic           negQ, negR, divZero;

  assign Busy   = (state != IDLE);
  assign accept = InValid && (state == IDLE);
  assign HiOut  = hiReg;
  assign LoOut  = loReg;

  assign isMul    = (Op[3:2] == 2'b10);
  assign isDiv    = (Op[3:1] == 3'b110);
  assign isSingle = !isMul && !isDiv;

  assign opB = ALUSrc ? Imm : SrcB;

  always_comb begin
    aluRes = '0;
    case (Op)
      4'd0:    aluRes = SrcA + opB;
      4'd1:    aluRes = SrcA - opB;
      4'd2:    aluRes = SrcA & opB;
      4'd3:    aluRes = SrcA | opB;
      4'd4:    aluRes = SrcA ^ opB;
      4'd5:    aluRes = ~(SrcA | opB);
      4'd6:    aluRes = {{(W-1){1'b0}},
                         $signed(SrcA) < $signed(opB)};
      4'd7:    aluRes = opB << SrcA[SW-1:0];
      4'd14:   aluRes = hiReg;
      4'd15:   aluRes = loReg;
      default: aluRes = '0;
    endcase
  end

  // Reserved MovCond 11 behaves as an ordinary instruction.
  assign movZ = (MovCond == 2'b01);
  assign movN = (MovCond == 2'b10);

  always_comb begin
    resNext = aluRes;
    wrNext  = RegWriteIn;
    unique case (1'b1)
      movZ: begin
        resNext = SrcA;
        wrNext  = (SrcB == '0);
      end
      movN: begin
        resNext = SrcA;
        wrNext  = (SrcB != '0);
      end
      default: ;
    endcase
  end

  assign mulSigned = (Op != 4'd9);
  assign divSigned = (Op == 4'd12);

  assign aExt = mulSigned ? {{W{SrcA[W-1]}}, SrcA}
                          : {{W{1'b0}}, SrcA};
  assign bExt = mulSigned ? {{W{opB[W-1]}}, opB}
                          : {{W{1'b0}}, opB};
  assign product = aExt * bExt;

  assign acc = {hiReg, loReg};

  always_comb begin
    accNext = prodReg;
    case (mulOp)
      2'b10:   accNext = acc + prodReg;
      2'b11:   accNext = acc - prodReg;
      default: accNext = prodReg;
    endcase
  end

  assign magA = (divSigned && SrcA[W-1]) ? -SrcA : SrcA;
  assign magB = (divSigned && opB[W-1]) ? -opB : opB;

  // One restoring step: shift the next dividend bit into the remainder.
  assign remShift = {rem, quo[W-1]};
  assign geq      = (remShift >= {1'b0, divisor});

  assign qFix = negQ ? -quo : quo;
  assign rFix = negR ? -rem : rem;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (accept && isMul)      stateNext = MUL;
        else if (accept && isDiv) stateNext = DIV;
      end
      MUL:    if (cnt == '0) stateNext = IDLE;
      DIV:    if (cnt == '0) stateNext = DIVFIX;
      DIVFIX: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      OutValid    <= 1'b0;
      Result      <= '0;
      DestReg     <= '0;
      RegWriteOut <= 1'b0;
      ZeroOut     <= 1'b0;
      hiReg       <= '0;
      loReg       <= '0;
      cnt         <= '0;
      prodReg     <= '0;
      mulOp       <= '0;
      divisor     <= '0;
      quo         <= '0;
      rem         <= '0;
      dividend    <= '0;
      negQ        <= 1'b0;
      negR        <= 1'b0;
      divZero     <= 1'b0;
    end else begin
      OutValid    <= 1'b0;
      RegWriteOut <= 1'b0;
      if (accept && isSingle) begin
        OutValid    <= 1'b1;
        Result      <= resNext;
        DestReg     <= RegDst ? RdField : RtField;
        RegWriteOut <= wrNext;
        ZeroOut     <= (resNext == '0);
      end
      unique case (state)
        IDLE: begin
          if (accept && isMul) begin
            cnt     <= CW'(MUL_LATENCY - 1);
            prodReg <= product;
            mulOp   <= Op[1:0];
          end else if (accept && isDiv) begin
            cnt      <= CW'(W - 1);
            rem      <= '0;
            quo      <= magA;
            divisor  <= magB;
            dividend <= SrcA;
            negQ     <= divSigned && (SrcA[W-1] ^ opB[W-1]);
            negR     <= divSigned && SrcA[W-1];
            divZero  <= (opB == '0);
          end
        end
        MUL: begin
          if (cnt == '0) {hiReg, loReg} <= accNext;
          else           cnt <= cnt - 1'b1;
        end
        DIV: begin
          rem <= geq ? remShift[W-1:0] - divisor
                     : remShift[W-1:0];
          quo <= {quo[W-2:0], geq};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DIVFIX: begin
          if (divZero) begin
            hiReg <= dividend;
            loReg <= '1;
          end else begin
            hiReg <= rFix;
            loReg <= qFix;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Directed bench for execute_muldiv_stage: vector table for the
// single-cycle path plus sequences for multiply, divide and reset.
module tb_execute_muldiv_stage;

  logic        Clk;
  logic        Reset;
  logic        InValid;
  logic [3:0]  Op;
  logic [31:0] SrcA, SrcB, Imm;
  logic        ALUSrc;
  logic [4:0]  RtField, RdField;
  logic        RegDst, RegWriteIn;
  logic [1:0]  MovCond;
  logic        Busy, OutValid;
  logic [31:0] Result;
  logic [4:0]  DestReg;
  logic        RegWriteOut, ZeroOut;
  logic [31:0] HiOut, LoOut;

  int nCmp = 0;
  int nBad = 0;

  execute_muldiv_stage #(
    .DATA_WIDTH (32),
    .MUL_LATENCY(2)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .InValid    (InValid),
    .Op         (Op),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .Imm        (Imm),
    .ALUSrc     (ALUSrc),
    .RtField    (RtField),
    .RdField    (RdField),
    .RegDst     (RegDst),
    .RegWriteIn (RegWriteIn),
    .MovCond    (MovCond),
    .Busy       (Busy),
    .OutValid   (OutValid),
    .Result     (Result),
    .DestReg    (DestReg),
    .RegWriteOut(RegWriteOut),
    .ZeroOut    (ZeroOut),
    .HiOut      (HiOut),
    .LoOut      (LoOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        src;
    logic [4:0]  rt, rd;
    logic        dst, rw;
    logic [1:0]  mc;
    logic [31:0] eRes;
    logic [4:0]  eDst;
    logic        eRw, eZ;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input logic [3:0]  op,
    input logic [31:0] a, b, imm,
    input logic        src,
    input logic [4:0]  rt, rd,
    input logic        dst, rw,
    input logic [1:0]  mc,
    input logic [31:0] eRes,
    input logic [4:0]  eDst,
    input logic        eRw, eZ
  );
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm;
    v.src = src; v.rt = rt; v.rd = rd;
    v.dst = dst; v.rw = rw; v.mc = mc;
    v.eRes = eRes; v.eDst = eDst;
    v.eRw = eRw; v.eZ = eZ;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Op = v.op; SrcA = v.a; SrcB = v.b; Imm = v.imm;
    ALUSrc = v.src; RtField = v.rt; RdField = v.rd;
    RegDst = v.dst; RegWriteIn = v.rw; MovCond = v.mc;
    InValid = 1'b1;
  endtask

  task automatic setOp(input logic [3:0] op,
                       input logic [31:0] a, b);
    Op = op; SrcA = a; SrcB = b; Imm = '0;
    ALUSrc = 1'b0; MovCond = 2'b00; RegWriteIn = 1'b1;
    RtField = 5'd1; RdField = 5'd2; RegDst = 1'b1;
    InValid = 1'b1;
  endtask

  task automatic runMulti(input string nm,
                          input logic [3:0] op,
                          input logic [31:0] a, b,
                          input int eBusy,
                          input logic [31:0] eHi, eLo);
    int n;
    @(negedge Clk);
    setOp(op, a, b);
    @(posedge Clk); #1;
    InValid = 1'b0;
    chk({nm, "_ov"}, 64'(OutValid), 64'(0));
    chk({nm, "_rw"}, 64'(RegWriteOut), 64'(0));
    n = 0;
    while (Busy && n < 200) begin
      n++;
      @(posedge Clk); #1;
    end
    chk({nm, "_busy"}, 64'(n), 64'(eBusy));
    chk({nm, "_hi"}, 64'(HiOut), 64'(eHi));
    chk({nm, "_lo"}, 64'(LoOut), 64'(eLo));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = mk(4'd0, 32'd5, 32'hFFFFFFFB, 0, 0, 5'd3, 5'd9,
                  0, 1, 2'b00, 32'd0, 5'd3, 1, 1);
    vecs[1]  = mk(4'd1, 32'd10, 32'd3, 0, 0, 5'd3, 5'd9,
                  1, 1, 2'b00, 32'd7, 5'd9, 1, 0);
    vecs[2]  = mk(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 5'd4,
                  5'd5, 0, 1, 2'b00, 32'h00F000F0, 5'd4, 1, 0);
    vecs[3]  = mk(4'd3, 32'hF0000000, 32'h0000000F, 0, 0, 5'd6,
                  5'd7, 1, 0, 2'b00, 32'hF000000F, 5'd7, 0, 0);
    vecs[4]  = mk(4'd4, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 5'd8,
                  5'd10, 0, 1, 2'b00, 32'hF0F00F0F, 5'd8, 1, 0);
    vecs[5]  = mk(4'd5, 32'd0, 32'd0, 0, 0, 5'd11, 5'd12,
                  1, 1, 2'b00, 32'hFFFFFFFF, 5'd12, 1, 0);
    vecs[6]  = mk(4'd6, 32'hFFFFFFFF, 32'd1, 0, 0, 5'd13, 5'd14,
                  1, 1, 2'b00, 32'd1, 5'd14, 1, 0);
    vecs[7]  = mk(4'd6, 32'd1, 32'hFFFFFFFF, 0, 0, 5'd13, 5'd14,
                  1, 1, 2'b00, 32'd0, 5'd14, 1, 1);
    vecs[8]  = mk(4'd7, 32'h24, 32'd1, 0, 0, 5'd15, 5'd16,
                  0, 1, 2'b00, 32'h10, 5'd15, 1, 0);
    vecs[9]  = mk(4'd0, 32'd100, 32'd999, 32'hFFFFFFFF, 1, 5'd17,
                  5'd18, 0, 1, 2'b00, 32'd99, 5'd17, 1, 0);
    vecs[10] = mk(4'd0, 32'h7FFFFFFF, 32'd1, 0, 0, 5'd19, 5'd20,
                  1, 1, 2'b00, 32'h80000000, 5'd20, 1, 0);
    vecs[11] = mk(4'd0, 32'h1234, 32'd0, 0, 0, 5'd21, 5'd22,
                  1, 0, 2'b01, 32'h1234, 5'd22, 1, 0);
    vecs[12] = mk(4'd0, 32'h1234, 32'd4, 0, 0, 5'd21, 5'd22,
                  1, 1, 2'b01, 32'h1234, 5'd22, 0, 0);
    vecs[13] = mk(4'd0, 32'h5678, 32'd4, 0, 0, 5'd23, 5'd24,
                  1, 0, 2'b10, 32'h5678, 5'd24, 1, 0);
    vecs[14] = mk(4'd0, 32'd2, 32'd3, 0, 0, 5'd25, 5'd26,
                  0, 1, 2'b11, 32'd5, 5'd25, 1, 0);
    vecs[15] = mk(4'd14, 32'd9, 32'd9, 0, 0, 5'd27, 5'd28,
                  1, 1, 2'b00, 32'd0, 5'd28, 1, 1);

    Reset = 1'b1;
    setOp(4'd0, 0, 0);
    InValid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 64'(Busy), 64'(0));
    chk("rst_ov", 64'(OutValid), 64'(0));
    chk("rst_res", 64'(Result), 64'(0));
    chk("rst_dst", 64'(DestReg), 64'(0));
    chk("rst_rw", 64'(RegWriteOut), 64'(0));
    chk("rst_z", 64'(ZeroOut), 64'(0));
    chk("rst_hi", 64'(HiOut), 64'(0));
    chk("rst_lo", 64'(LoOut), 64'(0));

    // Reset arriving mid-stream clears the registered outputs.
    @(negedge Clk);
    Reset = 1'b0;
    setOp(4'd3, 32'hA0, 32'h0B);
    @(posedge Clk); #1;
    chk("pre_res", 64'(Result), 64'hAB);
    @(negedge Clk);
    Reset = 1'b1;
    setOp(4'd0, 32'd1, 32'd1);
    @(posedge Clk); #1;
    chk("midrst_ov", 64'(OutValid), 64'(0));
    chk("midrst_res", 64'(Result), 64'(0));
    @(negedge Clk);
    Reset = 1'b0;
    InValid = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      drive(vecs[i]);
      @(posedge Clk); #1;
      chk($sformatf("v%0d_ov", i), 64'(OutValid), 64'(1));
      chk($sformatf("v%0d_res", i), 64'(Result),
          64'(vecs[i].eRes));
      chk($sformatf("v%0d_dst", i), 64'(DestReg),
          64'(vecs[i].eDst));
      chk($sformatf("v%0d_rw", i), 64'(RegWriteOut),
          64'(vecs[i].eRw));
      chk($sformatf("v%0d_z", i), 64'(ZeroOut),
          64'(vecs[i].eZ));
    end

    @(negedge Clk);
    InValid = 1'b0;
    @(posedge Clk); #1;
    chk("idle_ov", 64'(OutValid), 64'(0));
    chk("idle_rw", 64'(RegWriteOut), 64'(0));
    chk("idle_res", 64'(Result), 64'(0));
    chk("idle_z", 64'(ZeroOut), 64'(1));

    // MULT with an MFLO held on the inputs while Busy.
    @(negedge Clk);
    setOp(4'd8, 32'hFFFFFFFD, 32'd7);
    @(posedge Clk); #1;
    chk("mult_ov", 64'(OutValid), 64'(0));
    setOp(4'd15, 32'd0, 32'd0);
    n = 0;
    while (Busy && n < 200) begin
      chk("mult_ovbusy", 64'(OutValid), 64'(0));
      n++;
      @(posedge Clk); #1;
    end
    chk("mult_busy", 64'(n), 64'(2));
    chk("mult_hi", 64'(HiOut), 64'hFFFFFFFF);
    chk("mult_lo", 64'(LoOut), 64'hFFFFFFEB);
    @(posedge Clk); #1;
    InValid = 1'b0;
    chk("mflo_ov", 64'(OutValid), 64'(1));
    chk("mflo_res", 64'(Result), 64'hFFFFFFEB);

    runMulti("multu", 4'd9, 32'h49249249, 32'd7, 2,
             32'd1, 32'hFFFFFFFF);
    runMulti("madd", 4'd10, 32'h10000, 32'h10000, 2,
             32'd2, 32'hFFFFFFFF);
    runMulti("msub", 4'd11, 32'h10000, 32'h10000, 2,
             32'd1, 32'hFFFFFFFF);

    runMulti("div", 4'd12, 32'hFFFFFFF9, 32'd2, 33,
             32'hFFFFFFFF, 32'hFFFFFFFD);
    runMulti("divu0", 4'd13, 32'd7, 32'd0, 33,
             32'd7, 32'hFFFFFFFF);
    @(negedge Clk);
    setOp(4'd14, 32'd0, 32'd0);
    @(posedge Clk); #1;
    InValid = 1'b0;
    chk("mfhi_res", 64'(Result), 64'd7);
    runMulti("divovf", 4'd12, 32'h80000000, 32'hFFFFFFFF, 33,
             32'd0, 32'h80000000);

    // Reset ten cycles into a divide aborts it.
    @(negedge Clk);
    setOp(4'd12, 32'd100, 32'd3);
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (9) @(posedge Clk);
    #1;
    chk("abort_pre", 64'(Busy), 64'(1));
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort_busy", 64'(Busy), 64'(0));
    chk("abort_hi", 64'(HiOut), 64'(0));
    chk("abort_lo", 64'(LoOut), 64'(0));
    @(negedge Clk);
    Reset = 1'b0;
    setOp(4'd6, 32'hFFFFFFFF, 32'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    chk("slt_ov", 64'(OutValid), 64'(1));
    chk("slt_res", 64'(Result), 64'd1);
    repeat (40) @(posedge Clk);
    #1;
    chk("slt_hi", 64'(HiOut), 64'(0));
    chk("slt_busy", 64'(Busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nBad);
    $finish;
  end

endmodule
